// File: rtl/norm_shift_pipe_if.sv
// norm_shift_pipe_if: input and output channels of the normalization-shift
// stage. The master drives the input beat and consumes the result; the slave
// is the pipeline itself.
interface norm_shift_pipe_if #(
  parameter int EW = 13,
  parameter int FW = 57
);
  // input channel
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] fr;
  logic [EW-1:0] er;
  logic          db;
  logic          tiny;
  logic          ovf1;
  logic [5:0]    lz;

  // output channel
  logic          out_valid;
  logic          out_ready;
  logic [FW-2:0] fn;
  logic [EW-1:0] en;
  logic          sticky;
  logic          ovf1_o;
  logic          tiny_o;
  logic          db_o;
  logic          zero_o;

  modport master (
    output in_valid, fr, er, db, tiny, ovf1, lz, out_ready,
    input  in_ready, out_valid, fn, en, sticky, ovf1_o, tiny_o, db_o, zero_o
  );

  modport slave (
    input  in_valid, fr, er, db, tiny, ovf1, lz, out_ready,
    output in_ready, out_valid, fn, en, sticky, ovf1_o, tiny_o, db_o, zero_o
  );
endinterface

// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage normalization shift between the flags block and
// the significand rounder.
//   Stage 1: registers the operand, the zero flag, the signed shift distance
//            sigma and the adjusted exponent er - sigma.
//   Stage 2: applies the shift (left for sigma >= 0, right with sticky
//            collection for sigma < 0) and registers the result.
// Build option NORM_DENORM_EN: when defined, tiny results are right-shifted by
// the exponent distance to emin (clamped to FW+1) to form a denormal; when not
// defined, tiny results are flushed to zero with en = emin and only the
// right-shift-by-one used for an overflowing significand is built.
module norm_shift_pipe #(
  parameter int EW = 13,
  parameter int FW = 57
) (
  input  logic             clk,
  input  logic             rst_n,
  norm_shift_pipe_if.slave bus
);

  // Largest useful right shift: beyond this every input bit is below bit 0.
  localparam int            RSH_MAX = FW + 1;
  localparam logic [EW-1:0] EMIN_SP = {EW{1'b0}} - EW'(8'd126);
  localparam logic [EW-1:0] EMIN_DP = {EW{1'b0}} - EW'(11'd1022);
  localparam logic [EW-1:0] ONE_E   = {{(EW-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r1_valid;
  logic r2_valid;
  logic w_s2_can_load;
  logic w_in_ready;

  assign w_s2_can_load = !r2_valid || bus.out_ready;
  assign w_in_ready    = !r1_valid || w_s2_can_load;
  assign bus.in_ready  = w_in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: shift distance and adjusted exponent
  // ---------------------------------------------------------------------------
  logic [EW-1:0] w_emin;
  logic [EW-1:0] w_lz_ext;
  logic [EW-1:0] w_sig;
  logic [EW-1:0] w_en1;
  logic          w_zero1;

  assign w_lz_ext = {{(EW-6){1'b0}}, bus.lz};
  assign w_zero1  = (bus.fr == {FW{1'b0}});

  // Select emin by format and derive sigma: tiny results shift to reach emin,
  // normal results shift so the leading one lands on bit FW-2.
  always_comb begin
    w_emin = EMIN_SP;
    w_sig  = {EW{1'b0}};
    if (bus.db) begin
      w_emin = EMIN_DP;
    end else begin
      w_emin = EMIN_SP;
    end
    if (bus.tiny) begin
      w_sig = bus.er - w_emin;
    end else begin
      w_sig = w_lz_ext - ONE_E;
    end
    w_en1 = bus.er - w_sig;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [FW-1:0] r1_fr;
  logic [EW-1:0] r1_sig;
  logic [EW-1:0] r1_en;
  logic          r1_zero;
  logic          r1_tiny;
  logic          r1_ovf1;
  logic          r1_db;

  // Capture an accepted beat; hold while stage 1 is full and stage 2 stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_fr    <= {FW{1'b0}};
      r1_sig   <= {EW{1'b0}};
      r1_en    <= {EW{1'b0}};
      r1_zero  <= 1'b0;
      r1_tiny  <= 1'b0;
      r1_ovf1  <= 1'b0;
      r1_db    <= 1'b0;
    end else if (w_in_ready) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_fr   <= bus.fr;
        r1_sig  <= w_sig;
        r1_en   <= w_en1;
        r1_zero <= w_zero1;
        r1_tiny <= bus.tiny;
        r1_ovf1 <= bus.ovf1;
        r1_db   <= bus.db;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: the shifter
  // ---------------------------------------------------------------------------
  logic          w_sig_neg;
  logic          w_shl_big;
  logic [FW-2:0] w_shl;
  logic [FW-2:0] w_fn;
  logic [EW-1:0] w_en2;
  logic          w_sticky;

  assign w_sig_neg = r1_sig[EW-1];
  // A left distance past the word width leaves nothing in the result field.
  assign w_shl_big = |r1_sig[EW-2:6];
  // The top integer bit always falls out of a left-shifted 56-bit result.
  assign w_shl     = r1_fr[FW-2:0] << r1_sig[5:0];

`ifdef NORM_DENORM_EN
  logic [EW-1:0]         w_mag;
  logic [6:0]            w_amt;
  logic [FW+RSH_MAX-2:0] w_rsh_pre;
  logic [FW+RSH_MAX-2:0] w_rsh;

  localparam logic [EW-1:0] RSH_MAX_E = EW'(RSH_MAX);
  localparam logic [6:0]    RSH_MAX_A = 7'(RSH_MAX);

  assign w_mag = {EW{1'b0}} - r1_sig;

  // Clamp the right-shift magnitude; at the clamp all bits land in sticky.
  always_comb begin
    w_amt = 7'd0;
    if (w_mag > RSH_MAX_E) begin
      w_amt = RSH_MAX_A;
    end else begin
      w_amt = w_mag[6:0];
    end
  end

  // Operand is pre-shifted by one (the path is only used for sigma <= -1), so
  // the wide word holds the result field on top and the sticky field below.
  assign w_rsh_pre = {r1_fr, {(RSH_MAX-1){1'b0}}};
  assign w_rsh     = w_rsh_pre >> (w_amt - 7'd1);
`endif

  // Form fn/en/sticky: zero wins, then flush (when built), then the shift.
  always_comb begin
    w_fn     = {(FW-1){1'b0}};
    w_sticky = 1'b0;
    w_en2    = r1_en;
    if (r1_zero) begin
      w_en2 = {EW{1'b0}};
    end
`ifndef NORM_DENORM_EN
    else if (r1_tiny) begin
      // r1_en already equals emin for tiny inputs
      w_fn     = {(FW-1){1'b0}};
      w_sticky = 1'b0;
    end
`endif
    else if (!w_sig_neg) begin
      if (w_shl_big) begin
        w_fn = {(FW-1){1'b0}};
      end else begin
        w_fn = w_shl;
      end
    end else begin
`ifdef NORM_DENORM_EN
      w_fn     = w_rsh[FW+RSH_MAX-2:RSH_MAX];
      w_sticky = |w_rsh[RSH_MAX-1:0];
`else
      w_fn     = r1_fr[FW-1:1];
      w_sticky = r1_fr[0];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs directly)
  // ---------------------------------------------------------------------------
  logic [FW-2:0] r2_fn;
  logic [EW-1:0] r2_en;
  logic          r2_sticky;
  logic          r2_ovf1;
  logic          r2_tiny;
  logic          r2_db;
  logic          r2_zero;

  // Advance stage 1 into the output register unless the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_fn     <= {(FW-1){1'b0}};
      r2_en     <= {EW{1'b0}};
      r2_sticky <= 1'b0;
      r2_ovf1   <= 1'b0;
      r2_tiny   <= 1'b0;
      r2_db     <= 1'b0;
      r2_zero   <= 1'b0;
    end else if (w_s2_can_load) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_fn     <= w_fn;
        r2_en     <= w_en2;
        r2_sticky <= w_sticky;
        r2_ovf1   <= r1_ovf1;
        r2_tiny   <= r1_tiny;
        r2_db     <= r1_db;
        r2_zero   <= r1_zero;
      end
    end
  end

  assign bus.out_valid = r2_valid;
  assign bus.fn        = r2_fn;
  assign bus.en        = r2_en;
  assign bus.sticky    = r2_sticky;
  assign bus.ovf1_o    = r2_ovf1;
  assign bus.tiny_o    = r2_tiny;
  assign bus.db_o      = r2_db;
  assign bus.zero_o    = r2_zero;

endmodule
